// File: rtl/argmax_stream_n.sv
// argmax_stream_n: streaming argmax over blocks of N valid samples, reporting index, value and 1/(2*pi)-scaled angle
module argmax_stream_n #(
  parameter int N = 256,
  parameter int IDX_W = $clog2(N),
  parameter int VAL_W = 14,
  parameter int ANG_W = 11,
  parameter int ANG_F = 8,
  parameter int EPS_W = 22,
  parameter int EPS_F = 20,
  parameter logic [7:0] INV2PI_RAW = 8'd40,
  parameter int SKIP = 20,
  parameter bit TIE_LAST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    resync,
  input  logic signed [VAL_W-1:0] lambda_in,
  input  logic signed [ANG_W-1:0] angle_in,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        theta_out,
  output logic signed [VAL_W-1:0] max_out,
  output logic signed [EPS_W-1:0] eps_out,
  output logic                    busy
);
  localparam int SK_W = SKIP > 1 ? $clog2(SKIP) : 1;
  localparam int PW = ANG_W + 9;
  localparam int SH = EPS_F - ANG_F - 8;
  localparam logic signed [VAL_W-1:0] VAL_MIN = {1'b1, {(VAL_W-1){1'b0}}};
  typedef enum logic {S_SKIP, S_ACCUM} state_t;
  state_t state, nstate;
  logic [SK_W-1:0] skip_cnt;
  logic [IDX_W-1:0] idx_cnt, idx_q, win_idx;
  logic signed [VAL_W-1:0] max_q, win_val;
  logic signed [ANG_W-1:0] ang_q, win_ang;
  logic signed [PW-1:0] prod;
  logic signed [EPS_W-1:0] eps_n;
  logic skip_last, take, acc, last;
  assign skip_last = skip_cnt == SK_W'(SKIP - 1);
  assign busy = state == S_ACCUM;
  // state register; reset and resync land in SKIP unless no samples are to be skipped
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= (SKIP == 0) ? S_ACCUM : S_SKIP;
    else state <= nstate;
  // next state: resync restarts the skip phase, the last skipped sample opens accumulation
  always_comb begin
    nstate = state;
    if (resync) nstate = (SKIP == 0) ? S_ACCUM : S_SKIP;
    else if (in_valid && state == S_SKIP && skip_last) nstate = S_ACCUM;
  end
  // winner after folding in the current sample; position 0 always loads so a minimum value can still win
  always_comb begin
    acc = in_valid && !resync && state == S_ACCUM;
    last = acc && idx_cnt == IDX_W'(N - 1);
    take = idx_cnt == '0 || lambda_in > max_q || (TIE_LAST && lambda_in == max_q);
    win_val = take ? lambda_in : max_q;
    win_ang = take ? angle_in : ang_q;
    win_idx = take ? idx_cnt : idx_q;
    prod = PW'(win_ang) * PW'($signed({1'b0, INV2PI_RAW}));
    eps_n = EPS_W'(prod) <<< SH;
  end
  // counters, held maximum and result registers; a completed block is published one cycle later
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      skip_cnt <= '0;
      idx_cnt <= '0;
      max_q <= VAL_MIN;
      ang_q <= '0;
      idx_q <= '0;
      out_valid <= 1'b0;
      theta_out <= '0;
      max_out <= '0;
      eps_out <= '0;
    end else begin
      out_valid <= last;
      if (last) begin
        theta_out <= win_idx;
        max_out <= win_val;
        eps_out <= eps_n;
      end
      if (resync) begin
        skip_cnt <= '0;
        idx_cnt <= '0;
        max_q <= VAL_MIN;
        ang_q <= '0;
        idx_q <= '0;
      end else if (in_valid && state == S_SKIP) begin
        skip_cnt <= skip_last ? '0 : skip_cnt + SK_W'(1);
        idx_cnt <= '0;
      end else if (acc) begin
        max_q <= win_val;
        ang_q <= win_ang;
        idx_q <= win_idx;
        idx_cnt <= last ? '0 : idx_cnt + IDX_W'(1);
      end
    end
endmodule

// File: tb/tb_argmax_stream_n.sv
// tb_argmax_stream_n: directed bench with a block-level argmax model for both tie policies
module tb_argmax_stream_n;
  localparam int N = 4;
  localparam int SKIP = 2;
  logic clk = 1'b0;
  logic rst, in_valid, resync;
  logic signed [13:0] lambda;
  logic signed [10:0] angle;
  logic l_valid, f_valid, l_busy, f_busy;
  logic [1:0] l_theta, f_theta;
  logic signed [13:0] l_max, f_max;
  logic signed [21:0] l_eps, f_eps;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  argmax_stream_n #(.N(N), .SKIP(SKIP), .TIE_LAST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .resync(resync), .lambda_in(lambda), .angle_in(angle),
    .out_valid(l_valid), .theta_out(l_theta), .max_out(l_max), .eps_out(l_eps), .busy(l_busy));
  argmax_stream_n #(.N(N), .SKIP(SKIP), .TIE_LAST(1'b0)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .resync(resync), .lambda_in(lambda), .angle_in(angle),
    .out_valid(f_valid), .theta_out(f_theta), .max_out(f_max), .eps_out(f_eps), .busy(f_busy));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // angle (Q3.8) times 1/(2*pi) expressed in Q1.20, wrapped to 22 bits
  function automatic longint eps_of(input int a);
    int p;
    logic signed [21:0] w;
    p = a * 40 * 16;
    w = p[21:0];
    return longint'(w);
  endfunction

  // block-level model: discard SKIP samples, collect N samples, then pick winners by plain search
  int lam[N], ang[N];
  int cnt, skipped;
  bit in_skip, e_valid;
  int e_th_l, e_th_f, e_max;
  longint e_eps_l, e_eps_f;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_skip = 1; skipped = 0; cnt = 0; e_valid = 0;
      e_th_l = 0; e_th_f = 0; e_max = 0; e_eps_l = 0; e_eps_f = 0;
    end else begin
      e_valid = 0;
      if (resync) begin
        in_skip = 1; skipped = 0; cnt = 0;
      end else if (in_valid) begin
        if (in_skip) begin
          skipped++;
          if (skipped == SKIP) begin in_skip = 0; cnt = 0; end
        end else begin
          lam[cnt] = int'(lambda);
          ang[cnt] = int'(angle);
          cnt++;
          if (cnt == N) begin
            int bl, bf;
            bl = 0; bf = 0;
            for (int i = 1; i < N; i++) begin
              if (lam[i] >= lam[bl]) bl = i;
              if (lam[i] > lam[bf]) bf = i;
            end
            e_valid = 1; e_th_l = bl; e_th_f = bf; e_max = lam[bl];
            e_eps_l = eps_of(ang[bl]); e_eps_f = eps_of(ang[bf]);
            cnt = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("l_valid", longint'(l_valid), longint'(e_valid));
    chk("f_valid", longint'(f_valid), longint'(e_valid));
    chk("l_busy", longint'(l_busy), longint'(!in_skip));
    chk("f_busy", longint'(f_busy), longint'(!in_skip));
    chk("l_theta", longint'(l_theta), longint'(e_th_l));
    chk("f_theta", longint'(f_theta), longint'(e_th_f));
    chk("l_max", longint'(l_max), longint'(e_max));
    chk("f_max", longint'(f_max), longint'(e_max));
    chk("l_eps", longint'(l_eps), e_eps_l);
    chk("f_eps", longint'(f_eps), e_eps_f);
  end

  task automatic send(input int l, input int a);
    @(negedge clk);
    in_valid = 1'b1; resync = 1'b0; lambda = 14'(l); angle = 11'(a);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; resync = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; resync = 1'b0; lambda = '0; angle = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(l_busy), 0);
    chk("rst_max", longint'(l_max), 0);
    rst = 1'b0;
    send(11, 1); send(-7, 2);
    send(5, 10); send(-3, 20); send(9, 30); send(2, 40);
    idle(1);
    chk("t1_valid", longint'(l_valid), 1);
    chk("t1_theta", longint'(l_theta), 2);
    chk("t1_max", longint'(l_max), 9);
    chk("t1_eps", longint'(l_eps), 19200);
    send(7, 1); send(7, 2); send(1, 3); send(7, 4);
    idle(1);
    chk("tie_first", longint'(f_theta), 0);
    chk("tie_last", longint'(l_theta), 3);
    chk("tie_last_eps", longint'(l_eps), 2560);
    chk("tie_first_eps", longint'(f_eps), 640);
    send(1, 5); send(2, 6); send(3, 7); send(4, 8);
    send(8, 9); send(0, 10); send(0, 11); send(0, 12);
    idle(1);
    chk("b2b_theta", longint'(l_theta), 0);
    chk("b2b_max", longint'(l_max), 8);
    for (int i = 0; i < 4; i++) begin
      send(i + 1, i + 1);
      if (i < 3) idle(3);
    end
    idle(1);
    chk("gap_valid", longint'(l_valid), 1);
    chk("gap_theta", longint'(l_theta), 3);
    chk("gap_eps", longint'(l_eps), 2560);
    send(0, 0); send(0, 0); send(100, -256); send(0, 0);
    idle(1);
    chk("neg_eps", longint'(l_eps), -163840);
    chk("neg_theta", longint'(l_theta), 2);
    send(50, 1); send(60, 2);
    @(negedge clk); in_valid = 1'b1; resync = 1'b1; lambda = 14'(99); angle = 11'(3);
    send(127, 5); send(127, 6);
    send(3, 1); send(1, 2); send(1, 3); send(1, 4);
    idle(1);
    chk("resync_theta", longint'(l_theta), 0);
    chk("resync_max", longint'(l_max), 3);
    send(1, 1); send(1, 2); send(6, 3); send(1, 4);
    @(negedge clk); in_valid = 1'b1; resync = 1'b1; lambda = 14'(50); angle = 11'(9);
    chk("resync_strobe", longint'(l_valid), 1);
    send(9, 9); send(9, 9);
    send(2, 1); send(5, 2); send(1, 3); send(1, 4);
    send(1, 1); send(1, 2); send(1, 3);
    @(negedge clk); in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", longint'(l_valid), 0);
    chk("arst_theta", longint'(l_theta), 0);
    chk("arst_max", longint'(l_max), 0);
    chk("arst_eps", longint'(l_eps), 0);
    chk("arst_busy", longint'(l_busy), 0);
    @(negedge clk); rst = 1'b0;
    send(1, 1); send(1, 1);
    send(-8192, 1); send(-8192, 2); send(-8192, 3); send(-8192, 4);
    idle(1);
    chk("min_first_theta", longint'(f_theta), 0);
    chk("min_first_max", longint'(f_max), -8192);
    chk("min_last_theta", longint'(l_theta), 3);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
